// File: rtl/core_pkg.sv
// Shared constants and types for the single-cycle RV32I core.
// Opcodes, funct3/funct7 codes, ALU operation and write-back source encodings.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef CORE_MUL_EN
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
`endif

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_LINK,
        WB_LOAD,
        WB_MUL
    } wb_sel_e;

    // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA.
    function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_core_if.sv
// Instruction fetch bus between the core datapath and its instruction memory.
interface rv32i_core_if;
    import core_pkg::*;

    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] instr;

    modport master (output addr, input instr);
    modport slave  (input addr, output instr);
endinterface

// File: rtl/rv_imem.sv
// Byte-array instruction memory with combinational little-endian 32-bit fetch.
// The address wraps modulo IMEM_BYTES; contents are loaded by backdoor writes.
module rv_imem
    import core_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 4096
) (
    rv32i_core_if.slave bus
);

    localparam int unsigned AW = $clog2(IMEM_BYTES);

    logic [7:0]    memory [0:IMEM_BYTES-1] = '{default: 8'h00};
    logic [AW-1:0] a0;
    logic          unused_addr_hi;

    assign a0             = bus.addr[AW-1:0];
    assign unused_addr_hi = ^bus.addr[XLEN-1:AW];

    // Each byte address wraps independently so a fetch can straddle the end.
    assign bus.instr = {memory[a0 + AW'(3)], memory[a0 + AW'(2)],
                        memory[a0 + AW'(1)], memory[a0]};

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back in one clock.
// Optional macro CORE_MUL_EN adds MUL/MULH/MULHSU/MULHU; otherwise those encodings are NOPs.
module rv32i_core
    import core_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 4096,
    parameter int unsigned DMEM_BYTES = 4096,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);

    localparam int unsigned DW = $clog2(DMEM_BYTES);

    logic [XLEN-1:0] pc                 = RESET_PC;
    logic [XLEN-1:0] regs [0:31]        = '{default: '0};
    logic [7:0]      dmem [0:DMEM_BYTES-1] = '{default: 8'h00};

    rv32i_core_if ifetch ();

    assign ifetch.addr = pc;

    rv_imem #(.IMEM_BYTES(IMEM_BYTES)) inst_mem (.bus(ifetch.slave));

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_target;

    assign instr  = ifetch.instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Asynchronous reads; a same-cycle write is seen only after the edge.
    assign rs1_val     = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val     = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign pc_plus4    = pc + 32'd4;
    assign jalr_target = (rs1_val + imm_i) & ~32'd1;

    alu_op_e         alu_op;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            reg_we;
    logic            mem_we;
    logic            branch_taken;
    logic            load_ok;
    logic            store_ok;

    always_comb begin
        case (funct3)
            F3_BEQ:  branch_taken = (rs1_val == rs2_val);
            F3_BNE:  branch_taken = (rs1_val != rs2_val);
            F3_BLT:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: branch_taken = (rs1_val < rs2_val);
            F3_BGEU: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    assign load_ok  = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                      (funct3 == F3_LBU) || (funct3 == F3_LHU);
    assign store_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);

    // Decode; anything not matched falls through as a NOP with pc+4.
    always_comb begin
        alu_op  = ALU_ADD;
        alu_a   = rs1_val;
        alu_b   = rs2_val;
        wb_sel  = WB_ALU;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_PASS_B;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a  = pc;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_JAL: begin
                wb_sel  = WB_LINK;
                reg_we  = 1'b1;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == F3_JALR) begin
                    wb_sel  = WB_LINK;
                    reg_we  = 1'b1;
                    next_pc = jalr_target;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken) next_pc = pc + imm_b;
            end
            OPC_LOAD: begin
                alu_b  = imm_i;
                wb_sel = WB_LOAD;
                reg_we = load_ok;
            end
            OPC_STORE: begin
                alu_b  = imm_s;
                mem_we = store_ok;
            end
            OPC_OP_IMM: begin
                alu_b  = imm_i;
                alu_op = alu_op_from(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
                if (funct3 == F3_SLL)     reg_we = (funct7 == F7_BASE);
                else if (funct3 == F3_SR) reg_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else                      reg_we = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    alu_op = alu_op_from(funct3, 1'b0);
                    reg_we = 1'b1;
                end else if ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))) begin
                    alu_op = alu_op_from(funct3, 1'b1);
                    reg_we = 1'b1;
                end
`ifdef CORE_MUL_EN
                else if ((funct7 == F7_MULDIV) &&
                         ((funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                          (funct3 == F3_MULHSU) || (funct3 == F3_MULHU))) begin
                    wb_sel = WB_MUL;
                    reg_we = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLL:  alu_res = alu_a << alu_b[4:0];
            ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            default:  alu_res = alu_b;
        endcase
    end

`ifdef CORE_MUL_EN
    logic [32:0]        mul_a;
    logic [32:0]        mul_b;
    logic signed [65:0] mul_prod;
    logic [XLEN-1:0]    mul_res;
    logic               unused_mul_hi;

    // 33-bit operands let one signed multiplier cover all four signedness cases.
    always_comb begin
        mul_a    = {((funct3 == F3_MULH) || (funct3 == F3_MULHSU)) ? rs1_val[31] : 1'b0, rs1_val};
        mul_b    = {(funct3 == F3_MULH) ? rs2_val[31] : 1'b0, rs2_val};
        mul_prod = $signed(mul_a) * $signed(mul_b);
        mul_res  = (funct3 == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
    end

    assign unused_mul_hi = ^mul_prod[65:64];
`endif

    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;

    // Byte-granular, wrapping addresses make misaligned accesses free.
    assign d0 = alu_res[DW-1:0];
    assign d1 = d0 + DW'(1);
    assign d2 = d0 + DW'(2);
    assign d3 = d0 + DW'(3);

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{dmem[d0][7]}}, dmem[d0]};
            F3_LH:   load_data = {{16{dmem[d1][7]}}, dmem[d1], dmem[d0]};
            F3_LBU:  load_data = {24'h000000, dmem[d0]};
            F3_LHU:  load_data = {16'h0000, dmem[d1], dmem[d0]};
            default: load_data = {dmem[d3], dmem[d2], dmem[d1], dmem[d0]};
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_LINK: wb_data = pc_plus4;
            WB_LOAD: wb_data = load_data;
`ifdef CORE_MUL_EN
            WB_MUL:  wb_data = mul_res;
`endif
            default: wb_data = alu_res;
        endcase
    end

    // Reset aborts the current instruction: only the pc is touched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
            if (reg_we && (rd != 5'd0)) regs[rd] <= wb_data;
            if (mem_we) begin
                dmem[d0] <= rs2_val[7:0];
                if ((funct3 == F3_SH) || (funct3 == F3_SW)) dmem[d1] <= rs2_val[15:8];
                if (funct3 == F3_SW) begin
                    dmem[d2] <= rs2_val[23:16];
                    dmem[d3] <= rs2_val[31:24];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: backdoor-loaded program, stepped one instruction at a time.
module tb_rv32i_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_regs [0:31];

    rv32i_core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s x%0d", tag, i), dut.regs[i], exp_regs[i]);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input int unsigned a, input logic [31:0] w);
        dut.inst_mem.memory[a]     = w[7:0];
        dut.inst_mem.memory[a + 1] = w[15:8];
        dut.inst_mem.memory[a + 2] = w[23:16];
        dut.inst_mem.memory[a + 3] = w[31:24];
    endtask

    function automatic logic [31:0] dword(input int unsigned a);
        return {dut.dmem[a + 3], dut.dmem[a + 2], dut.dmem[a + 1], dut.dmem[a]};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        #1;
        put(32'h00, 32'h00500093); // addi x1,x0,5
        put(32'h04, 32'hFFD08113); // addi x2,x1,-3
        put(32'h08, 32'h00700013); // addi x0,x0,7
        put(32'h0C, 32'h123451B7); // lui  x3,0x12345
        put(32'h10, 32'h67818193); // addi x3,x3,0x678
        put(32'h14, 32'h40300233); // sub  x4,x0,x3
        put(32'h18, 32'h40425293); // srai x5,x4,4
        put(32'h1C, 32'h00302023); // sw   x3,0(x0)
        put(32'h20, 32'h00108463); // beq  x1,x1,+8
        put(32'h24, 32'h00100493); // addi x9,x0,1 (skipped)
        put(32'h28, 32'h00109463); // bne  x1,x1,+8
        put(32'h2C, 32'h00100303); // lb   x6,1(x0)
        put(32'h30, 32'h010000EF); // jal  x1,+16
        put(32'h34, 32'h01C0006F); // jal  x0,+28
        put(32'h40, 32'h00108067); // jalr x0,x1,1
        put(32'h50, 32'h00304383); // lbu  x7,3(x0)
        put(32'h54, 32'h00201403); // lh   x8,2(x0)
        put(32'h58, 32'h001002A3); // sb   x1,5(x0)
        put(32'h5C, 32'hFFFFFFFF); // illegal
        put(32'h60, 32'h00000073); // ecall
        put(32'h64, 32'hFFF00593); // addi x11,x0,-1
        put(32'h68, 32'h00200613); // addi x12,x0,2
        put(32'h6C, 32'h02C58533); // mul   x10,x11,x12
        put(32'h70, 32'h02C5B6B3); // mulhu x13,x11,x12
        put(32'h74, 32'h00122733); // slt  x14,x4,x1
        put(32'h78, 32'h001237B3); // sltu x15,x4,x1
        put(32'h7C, 32'h00302423); // sw   x3,8(x0) (aborted by reset)
        dut.pc = 32'h40;

        step(); step();
        check("reset pc", dut.pc, 32'h0);
        rst = 1'b0;

        step(); exp_regs[1] = 32'd5;
        check("addi pc", dut.pc, 32'h4);
        check("addi x1", dut.regs[1], exp_regs[1]);
        step(); exp_regs[2] = 32'd2;
        check("addi neg x2", dut.regs[2], exp_regs[2]);
        step();
        check("x0 write", dut.regs[0], 32'h0);
        step(); step(); exp_regs[3] = 32'h12345678;
        check("lui+addi x3", dut.regs[3], exp_regs[3]);
        step(); exp_regs[4] = 32'hEDCBA988;
        check("sub x4", dut.regs[4], exp_regs[4]);
        step(); exp_regs[5] = 32'hFEDCBA98;
        check("srai x5", dut.regs[5], exp_regs[5]);
        step();
        check("sw word", dword(0), 32'h12345678);
        step();
        check("beq taken pc", dut.pc, 32'h28);
        step();
        check("bne not taken pc", dut.pc, 32'h2C);
        check("skipped x9", dut.regs[9], 32'h0);
        step(); exp_regs[6] = 32'h00000056;
        check("lb x6", dut.regs[6], exp_regs[6]);
        step(); exp_regs[1] = 32'h34;
        check("jal pc", dut.pc, 32'h40);
        check("jal link x1", dut.regs[1], exp_regs[1]);
        step();
        check("jalr pc", dut.pc, 32'h34);
        step();
        check("jal x0 pc", dut.pc, 32'h50);
        step(); exp_regs[7] = 32'h12;
        check("lbu x7", dut.regs[7], exp_regs[7]);
        step(); exp_regs[8] = 32'h1234;
        check("lh x8", dut.regs[8], exp_regs[8]);
        step();
        check("sb byte5", dword(4), 32'h00003400);
        check("sb word0 kept", dword(0), 32'h12345678);
        step();
        check("illegal pc", dut.pc, 32'h60);
        check_regs("illegal");
        step();
        check("ecall pc", dut.pc, 32'h64);
        check_regs("ecall");
        check("ecall mem", dword(4), 32'h00003400);
        step(); step(); exp_regs[11] = 32'hFFFFFFFF; exp_regs[12] = 32'h2;
        step();
`ifdef CORE_MUL_EN
        exp_regs[10] = 32'hFFFFFFFE;
`endif
        check("mul x10", dut.regs[10], exp_regs[10]);
        step();
`ifdef CORE_MUL_EN
        exp_regs[13] = 32'h1;
`endif
        check("mulhu x13", dut.regs[13], exp_regs[13]);
        step(); exp_regs[14] = 32'h1;
        check("slt x14", dut.regs[14], exp_regs[14]);
        step();
        check("sltu x15", dut.regs[15], 32'h0);
        check("pc before reset", dut.pc, 32'h7C);

        rst = 1'b1;
        step();
        check("mid reset pc", dut.pc, 32'h0);
        check("mid reset no store", dword(8), 32'h0);
        check_regs("mid reset");
        rst = 1'b0;
        step(); exp_regs[1] = 32'd5;
        check("rerun x1", dut.regs[1], exp_regs[1]);
        check("rerun pc", dut.pc, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
